riscoffee_fetch: RTL and testbench
==================================

Name: riscoffee_fetch

Overview:
Instruction fetch stage, the producer side of the decode interface: it drives INST_CODE and DE_READY into riscoffee_decode and tracks the PC of each instruction handed over. It issues word requests to instruction memory over a req/gnt/rvalid handshake, buffers returned words in a 2-entry queue, and holds them while execute stalls. It redirects on taken branch/jump/trap from execute and discards any stale in-flight response.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset.
QUEUE_DEPTH, 2, instruction queue entries; only 2 is supported.

Ports:
CLK  in  1  clock.
RST_N  in  1  reset, asynchronous, active-low.
EX_STALL  in  1  execute stalled; decode must not load a new instruction.
BRANCH_TAKEN  in  1  single-cycle redirect pulse from execute.
BRANCH_PC  in  32  redirect target.
IMEM_REQ  out  1  fetch request valid.
IMEM_ADDR  out  32  word address of the request; bits [1:0] always 0.
IMEM_GNT  in  1  request accepted this cycle.
IMEM_RVALID  in  1  read data valid.
IMEM_RDATA  in  32  instruction word.
DE_READY  out  1  INST_CODE is valid and is consumed this cycle.
INST_CODE  out  32  instruction to decode.
IF_PC  out  32  PC of INST_CODE.

Behaviour:
- Reset (async assert): FSM=IDLE, fetch_pc=RESET_PC, queue empty, drop flag clear. IMEM_REQ=0, IMEM_ADDR=RESET_PC, DE_READY=0, INST_CODE=32'h0000_0013 (NOP), IF_PC=RESET_PC. Instruction memory is reset together with this block, so no pre-reset response arrives after reset.
- Queue output:
  - DE_READY = queue non-empty && !EX_STALL && !BRANCH_TAKEN (combinational).
  - INST_CODE and IF_PC come from the queue head. When the queue is empty, they are NOP and fetch_pc.
  - The head pops on every cycle DE_READY=1.
- Request rule: at most one request outstanding. A new request is issued only when occupancy plus outstanding is less than 2, counting a pop in the same cycle.
- FSM:
  - IDLE: IMEM_REQ=0. Go to REQ when the request rule allows.
  - REQ: IMEM_REQ=1, IMEM_ADDR=fetch_pc. Both stay stable until IMEM_GNT. On GNT: fetch_pc += 4, go to WAIT.
  - WAIT: on IMEM_RVALID, push {pc, IMEM_RDATA} unless the drop flag is set. Next state is REQ if the rule allows, else IDLE.
- Latency: IMEM_RVALID at edge N means the word is in the queue after N, so DE_READY can be high in cycle N+1. There is no bypass path. IMEM_RVALID never arrives in the same cycle as its IMEM_GNT.
- Redirect (BRANCH_TAKEN=1):
  - The queue is cleared and fetch_pc becomes {BRANCH_PC[31:2], 2'b00}; misalignment is trapped in execute.
  - DE_READY is forced to 0 that cycle.
  - If a request is outstanding (in WAIT, or in REQ with GNT that cycle), set the drop flag. The flag clears on the next IMEM_RVALID, whose data is discarded. Then fetch at the new PC.
  - In REQ without GNT, the next cycle's IMEM_ADDR is the new PC. This is the only case where IMEM_ADDR may change while IMEM_REQ is high.
- Redirect coincident with IMEM_RVALID in WAIT: the returned data is discarded and no drop flag is set.
- Redirect coincident with a pop: the redirect wins.
- RVALID push plus pop on a full queue: occupancy is unchanged and order is preserved.
- PC arithmetic is 32-bit and wraps from 0xFFFF_FFFC to 0x0000_0000 with no special handling.

Decomposition:
- riscoffee_pkg holds the NOP constant 32'h0000_0013, the default RESET_PC and the fetch_state_t enum {IDLE, REQ, WAIT}.
- Sub-module riscoffee_fetch_queue: 2-entry {pc, inst} FIFO with push, pop, synchronous clear, count and head outputs. It uses the same async reset.

Test Plan:
- Release reset, memory with 1-cycle latency, mem[0]=0x00500093 -> IMEM_REQ=1 with IMEM_ADDR=0x0 in the first cycle; DE_READY=1 with INST_CODE=0x00500093, IF_PC=0x0 the cycle after RVALID; next IMEM_ADDR=0x4.
- Hold EX_STALL=1 for 4 cycles from PC 0x8 -> DE_READY=0; IMEM_REQ drops once 2 entries are queued; after release, DE_READY on consecutive cycles with IF_PC 0x8 then 0xC, no loss or duplication.
- BRANCH_TAKEN with BRANCH_PC=0x100 while in WAIT for 0x10 -> the response for 0x10 is dropped; next IMEM_ADDR=0x100; first DE_READY shows IF_PC=0x100.
- BRANCH_PC=0x103 -> IMEM_ADDR=0x100 and IF_PC=0x100.
- IMEM_GNT held low for 5 cycles -> IMEM_REQ=1 and IMEM_ADDR constant throughout; fetch_pc advances only after GNT.
- Assert RST_N=0 mid-WAIT, off a clock edge -> outputs take their reset values immediately; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/riscoffee_pkg.sv
// Shared fetch-stage types and constants.
// Imported by the fetch stage and its instruction queue.
package riscoffee_pkg;

  localparam logic [31:0] NOP          = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/riscoffee_fetch_queue.sv
// Two-entry {pc, inst} FIFO between imem responses and decode.
// Entry q0 is always the head; a push+pop keeps occupancy and order.
module riscoffee_fetch_queue
  import riscoffee_pkg::*;
(
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         clr,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  fetch_entry_t q0, q1;
  logic [1:0]   cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      q0  <= '0;
      q1  <= '0;
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) q0 <= push_data;
          else             q1 <= push_data;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          q0  <= q1;
          cnt <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            q0 <= push_data;
          end else begin
            q0 <= q1;
            q1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign count = cnt;
  assign head  = q0;

endmodule

// File: rtl/riscoffee_fetch.sv
// Instruction fetch stage: imem req/gnt/rvalid master feeding decode
// through a 2-entry queue, with redirect and stale-response dropping.
module riscoffee_fetch
  import riscoffee_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEF,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        EX_STALL,
  input  logic        BRANCH_TAKEN,
  input  logic [31:0] BRANCH_PC,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_GNT,
  input  logic        IMEM_RVALID,
  input  logic [31:0] IMEM_RDATA,
  output logic        DE_READY,
  output logic [31:0] INST_CODE,
  output logic [31:0] IF_PC
);

  localparam logic [1:0] FULL = 2'(QUEUE_DEPTH);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         drop_q, drop_d;

  logic [1:0]   cnt;
  fetch_entry_t head;
  fetch_entry_t push_data;
  logic         push, pop;
  logic [1:0]   occ_after;
  logic         room;
  logic [31:0]  br_pc;
  logic         unused_br_lsb;

  assign br_pc         = {BRANCH_PC[31:2], 2'b00};
  assign unused_br_lsb = ^BRANCH_PC[1:0];

  assign DE_READY = (cnt != 2'd0) && !EX_STALL && !BRANCH_TAKEN;
  assign pop      = DE_READY;

  // Response belongs to the granted address, one word behind fetch_pc.
  assign push = (state_q == WAIT) && IMEM_RVALID
              && !drop_q && !BRANCH_TAKEN;
  assign push_data.pc   = pc_q - 32'd4;
  assign push_data.inst = IMEM_RDATA;

  assign occ_after = cnt + {1'b0, push} - {1'b0, pop};
  assign room      = occ_after < FULL;

  riscoffee_fetch_queue u_queue (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .clr       (BRANCH_TAKEN),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .count     (cnt),
    .head      (head)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      pc_q    <= {RESET_PC[31:2], 2'b00};
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    drop_d   = drop_q;
    IMEM_REQ = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (BRANCH_TAKEN || room) state_d = REQ;
      end
      REQ: begin
        IMEM_REQ = 1'b1;
        if (IMEM_GNT) begin
          pc_d    = pc_q + 32'd4;
          state_d = WAIT;
          if (BRANCH_TAKEN) drop_d = 1'b1;
        end
      end
      WAIT: begin
        if (IMEM_RVALID) begin
          drop_d  = 1'b0;
          state_d = (BRANCH_TAKEN || room) ? REQ : IDLE;
        end else if (BRANCH_TAKEN) begin
          drop_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (BRANCH_TAKEN) pc_d = br_pc;
  end

  assign IMEM_ADDR = pc_q;
  assign INST_CODE = (cnt != 2'd0) ? head.inst : NOP;
  assign IF_PC     = (cnt != 2'd0) ? head.pc   : pc_q;

endmodule

// File: tb/tb_riscoffee_fetch.sv
// Self-checking bench for riscoffee_fetch: imem model with variable
// latency, sequential-stream scoreboard, redirect vector table.
module tb_riscoffee_fetch;
  import riscoffee_pkg::*;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b1;
  logic        EX_STALL = 1'b0;
  logic        BRANCH_TAKEN = 1'b0;
  logic [31:0] BRANCH_PC = '0;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_GNT;
  logic        IMEM_RVALID;
  logic [31:0] IMEM_RDATA;
  logic        DE_READY;
  logic [31:0] INST_CODE;
  logic [31:0] IF_PC;

  riscoffee_fetch dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .EX_STALL     (EX_STALL),
    .BRANCH_TAKEN (BRANCH_TAKEN),
    .BRANCH_PC    (BRANCH_PC),
    .IMEM_REQ     (IMEM_REQ),
    .IMEM_ADDR    (IMEM_ADDR),
    .IMEM_GNT     (IMEM_GNT),
    .IMEM_RVALID  (IMEM_RVALID),
    .IMEM_RDATA   (IMEM_RDATA),
    .DE_READY     (DE_READY),
    .INST_CODE    (INST_CODE),
    .IF_PC        (IF_PC)
  );

  always #5 CLK = ~CLK;

  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          lat = 1;
  logic        gnt_en = 1'b1;
  logic        pend;
  int          cnt_m;
  logic [31:0] paddr;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;
  exp_t        exp_q[$];
  logic [31:0] nxt_pc;

  logic        p_req = 1'b0;
  logic        p_gnt = 1'b0;
  logic        p_br = 1'b0;
  logic [31:0] p_addr = '0;

  typedef enum int {M_WAIT, M_NOGNT, M_GNT} mode_t;
  typedef struct {
    mode_t       mode;
    int          lat;
    logic [31:0] bpc;
    logic [31:0] exp_pc;
  } vec_t;
  vec_t vecs[5];

  function automatic logic [31:0] memword(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return {a[25:2], 8'h13};
  endfunction

  assign IMEM_GNT = IMEM_REQ && gnt_en && !pend;

  // Memory: grants immediately, returns data lat cycles after grant.
  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pend        <= 1'b0;
      cnt_m       <= 0;
      paddr       <= '0;
      IMEM_RVALID <= 1'b0;
      IMEM_RDATA  <= '0;
    end else begin
      IMEM_RVALID <= 1'b0;
      if (IMEM_GNT) begin
        if (lat <= 1) begin
          IMEM_RVALID <= 1'b1;
          IMEM_RDATA  <= memword(IMEM_ADDR);
        end else begin
          pend  <= 1'b1;
          cnt_m <= lat - 1;
          paddr <= IMEM_ADDR;
        end
      end else if (pend) begin
        if (cnt_m <= 1) begin
          IMEM_RVALID <= 1'b1;
          IMEM_RDATA  <= memword(paddr);
          pend        <= 1'b0;
        end else begin
          cnt_m <= cnt_m - 1;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic refill();
    while (exp_q.size() < 4) begin
      exp_t e;
      e.pc   = nxt_pc;
      e.inst = memword(nxt_pc);
      exp_q.push_back(e);
      nxt_pc = nxt_pc + 32'd4;
    end
  endtask

  task automatic restart(input logic [31:0] pc);
    exp_q.delete();
    nxt_pc = pc;
    refill();
  endtask

  task automatic cyc(input logic st = 1'b0, input logic br = 1'b0,
                     input logic [31:0] bpc = '0,
                     input logic g = 1'b1);
    @(negedge CLK);
    EX_STALL     = st;
    BRANCH_TAKEN = br;
    BRANCH_PC    = bpc;
    gnt_en       = g;
    if (br) restart({bpc[31:2], 2'b00});
    #1;
    if (p_req && !p_gnt && !p_br) begin
      chk("req_hold", 32'(IMEM_REQ), 32'd1);
      chk("addr_hold", IMEM_ADDR, p_addr);
    end
    if (DE_READY) begin
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 32'(DE_READY), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_pc", IF_PC, e.pc);
        chk("sb_inst", INST_CODE, e.inst);
        refill();
      end
    end
    p_req  = IMEM_REQ;
    p_gnt  = IMEM_GNT;
    p_br   = br;
    p_addr = IMEM_ADDR;
  endtask

  task automatic expect_req(input string nm, input logic [31:0] a);
    int n = 0;
    do begin cyc(); n++; end while (!IMEM_REQ && n < 30);
    chk({nm, "_req"}, 32'(IMEM_REQ), 32'd1);
    chk({nm, "_addr"}, IMEM_ADDR, a);
  endtask

  task automatic expect_de(input string nm, input logic [31:0] a);
    int n = 0;
    do begin cyc(); n++; end while (!DE_READY && n < 40);
    chk({nm, "_de"}, 32'(DE_READY), 32'd1);
    chk({nm, "_pc"}, IF_PC, a);
    chk({nm, "_inst"}, INST_CODE, memword(a));
    n = 0;
    do begin cyc(); n++; end while (!DE_READY && n < 40);
    chk({nm, "_pc2"}, IF_PC, a + 32'd4);
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, "_req"}, 32'(IMEM_REQ), 32'd0);
    chk({nm, "_addr"}, IMEM_ADDR, 32'h0);
    chk({nm, "_de"}, 32'(DE_READY), 32'd0);
    chk({nm, "_inst"}, INST_CODE, 32'h0000_0013);
    chk({nm, "_ifpc"}, IF_PC, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [31:0] a;
    vecs[0] = '{M_WAIT,  1, 32'h0000_0103, 32'h0000_0100};
    vecs[1] = '{M_WAIT,  2, 32'h0000_0202, 32'h0000_0200};
    vecs[2] = '{M_NOGNT, 1, 32'h0000_03FE, 32'h0000_03FC};
    vecs[3] = '{M_GNT,   2, 32'h0000_0500, 32'h0000_0500};
    vecs[4] = '{M_WAIT,  1, 32'hFFFF_FFFF, 32'hFFFF_FFFC};

    #1 RST_N = 1'b0;
    #12;
    chk_reset_outs("rst0");
    @(negedge CLK);
    RST_N = 1'b1;
    restart(32'h0);

    // First fetch with 1-cycle memory
    cyc();
    chk("first_req", 32'(IMEM_REQ), 32'd1);
    chk("first_addr", IMEM_ADDR, 32'h0);
    cyc();
    chk("next_addr", IMEM_ADDR, 32'h4);
    cyc();
    chk("first_de", 32'(DE_READY), 32'd1);
    chk("first_inst", INST_CODE, 32'h0050_0093);
    chk("first_pc", IF_PC, 32'h0);

    // Stall with head at 0x8
    n = 0;
    while (exp_q[0].pc != 32'h8 && n < 20) begin cyc(); n++; end
    chk("reach_pc8", exp_q[0].pc, 32'h8);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1);
      chk("stall_de", 32'(DE_READY), 32'd0);
    end
    chk("stall_req_drop", 32'(IMEM_REQ), 32'd0);
    chk("stall_head", IF_PC, 32'h8);
    lat = 3;
    cyc();
    chk("rel_de0", 32'(DE_READY), 32'd1);
    chk("rel_pc0", IF_PC, 32'h8);
    cyc();
    chk("rel_de1", 32'(DE_READY), 32'd1);
    chk("rel_pc1", IF_PC, 32'hC);

    // Redirect while waiting on 0x10
    n = 0;
    do begin cyc(); n++; end while (!(pend && paddr == 32'h10) && n < 20);
    chk("wait_0x10", paddr, 32'h10);
    cyc(1'b0, 1'b1, 32'h100);
    chk("br_de", 32'(DE_READY), 32'd0);
    expect_req("s3", 32'h100);
    expect_de("s3", 32'h100);

    // Redirect beats pop with a non-empty queue
    lat = 1;
    for (int i = 0; i < 8; i++) cyc(1'b1);
    chk("full_head_valid", 32'(INST_CODE != NOP), 32'd1);
    cyc(1'b0, 1'b1, 32'h700);
    chk("br_wins_de", 32'(DE_READY), 32'd0);
    expect_de("bw", 32'h700);

    // Grant withheld for several cycles
    n = 0;
    do begin cyc(1'b0, 1'b0, '0, 1'b0); n++; end
    while (!IMEM_REQ && n < 20);
    a = IMEM_ADDR;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, '0, 1'b0);
      chk("gh_req", 32'(IMEM_REQ), 32'd1);
      chk("gh_addr", IMEM_ADDR, a);
    end
    cyc();
    chk("gh_gnt", 32'(IMEM_GNT), 32'd1);
    cyc();
    chk("gh_adv", IMEM_ADDR, a + 32'd4);

    // Redirect vector table
    for (int i = 0; i < 5; i++) begin
      lat = vecs[i].lat;
      n = 0;
      unique case (vecs[i].mode)
        M_WAIT: begin
          do begin cyc(); n++; end
          while (!(pend || IMEM_RVALID) && n < 30);
          cyc(1'b0, 1'b1, vecs[i].bpc);
        end
        M_NOGNT: begin
          do begin cyc(1'b0, 1'b0, '0, 1'b0); n++; end
          while (!IMEM_REQ && n < 30);
          cyc(1'b0, 1'b1, vecs[i].bpc, 1'b0);
          cyc(1'b0, 1'b0, '0, 1'b0);
          chk("ng_req", 32'(IMEM_REQ), 32'd1);
          chk("ng_addr", IMEM_ADDR, vecs[i].exp_pc);
        end
        M_GNT: begin
          do begin cyc(1'b0, 1'b0, '0, 1'b0); n++; end
          while (!IMEM_REQ && n < 30);
          cyc(1'b0, 1'b1, vecs[i].bpc, 1'b1);
        end
        default: ;
      endcase
      expect_req("vec", vecs[i].exp_pc);
      expect_de("vec", vecs[i].exp_pc);
    end

    // Asynchronous reset in the middle of WAIT
    lat = 3;
    n = 0;
    do begin cyc(); n++; end while (!pend && n < 30);
    #2;
    RST_N = 1'b0;
    #1;
    chk_reset_outs("rst1");
    exp_q.delete();
    p_req = 1'b0;
    p_br  = 1'b0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    restart(32'h0);
    expect_req("rst1r", 32'h0);
    expect_de("rst1d", 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
